alu_exec: RTL and testbench

Multi-cycle integer execute unit sitting directly downstream of the ALU sub-control decoder. It consumes the 4-bit operation select plus two 32-bit operands and produces a registered 32-bit result and branch flags (`eq`, `lt`) through a start/done handshake. Logic and arithmetic operations complete in one cycle. Shifts use a 1-bit-per-cycle iterative shifter to save area on the IGLOO2 fabric, so they take 1 + shamt cycles.

---
 rtl/alu_exec.sv | 127 ++++++++++++
 tb/tb_alu_exec.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Multi-cycle integer execute unit: single-cycle logic/arithmetic ops and an
// iterative 1-bit-per-cycle shifter behind a start/busy/done handshake.
module alu_exec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  outsel,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        eq,
    output logic        lt,
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t      state;
    logic [31:0] shreg;
    logic [4:0]  cnt;
    logic [1:0]  shsel;
    logic        eq_q;
    logic        is_sh;
    logic [33:0] fn;

    // Returns {illegal, lt, result}; shift codes yield opa (the shamt=0 case).
    function automatic logic [33:0] alu_fn(input logic [3:0] sel,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        logic               l;
        logic               ill;
        sa  = a;
        sb  = b;
        r   = '0;
        l   = 1'b0;
        ill = 1'b0;
        case (sel)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: begin l = (sa < sb); r = {31'b0, l}; end
            4'b1000: begin l = (a < b);   r = {31'b0, l}; end
            4'b1001, 4'b1010, 4'b1011: r = a;
            4'b1100: r = a ^ b;
            default: ill = 1'b1;
        endcase
        return {ill, l, r};
    endfunction

    // sel is outsel[1:0]: 01 SLL, 10 SRL, 11 SRA.
    function automatic logic [31:0] shift1(input logic [1:0] sel,
                                           input logic [31:0] v);
        logic [31:0] r;
        case (sel)
            2'b01:   r = {v[30:0], 1'b0};
            2'b10:   r = {1'b0, v[31:1]};
            default: r = {v[31], v[31:1]};
        endcase
        return r;
    endfunction

    assign is_sh = (outsel == 4'b1001) || (outsel == 4'b1010) || (outsel == 4'b1011);
    assign fn    = alu_fn(outsel, opa, opb);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            eq      <= 1'b0;
            lt      <= 1'b0;
            illegal <= 1'b0;
            cnt     <= '0;
            shreg   <= '0;
            shsel   <= '0;
            eq_q    <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    shreg <= shift1(shsel, shreg);
                    cnt   <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        result  <= shift1(shsel, shreg);
                        eq      <= eq_q;
                        lt      <= 1'b0;
                        illegal <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= FIN;
                    end
                end
                // IDLE and FIN both accept; FIN acceptance gives back-to-back issue.
                default: begin
                    if (start) begin
                        if (is_sh && (opb[4:0] != 5'd0)) begin
                            shreg <= opa;
                            cnt   <= opb[4:0];
                            shsel <= outsel[1:0];
                            eq_q  <= (opa == opb);
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            state <= SHIFT;
                        end else begin
                            result  <= fn[31:0];
                            lt      <= fn[32];
                            illegal <= fn[33];
                            eq      <= (opa == opb);
                            done    <= 1'b1;
                            state   <= FIN;
                        end
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver pushes model expectations, a negedge
// monitor pops and checks them whenever done pulses.
module tb_alu_exec;

    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SLTU = 4'b1000,
                           OP_SLL = 4'b1001, OP_SRL = 4'b1010, OP_SRA = 4'b1011,
                           OP_XOR = 4'b1100, OP_NONE = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  outsel = '0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        busy, done, eq, lt, illegal;
    logic [31:0] result;

    alu_exec dut (
        .clk(clk), .rst_n(rst_n), .start(start), .outsel(outsel),
        .opa(opa), .opb(opb), .busy(busy), .done(done),
        .result(result), .eq(eq), .lt(lt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        eq;
        logic        lt;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;
    int   bfrom = -1;
    int   bto = -2;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic bit is_shift(input logic [3:0] sel);
        return (sel == OP_SLL) || (sel == OP_SRL) || (sel == OP_SRA);
    endfunction

    // Reference: architectural result of one instruction, no timing.
    function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sh;
        sh    = int'(b[4:0]);
        e.eq  = (a == b);
        e.lt  = 1'b0;
        e.ill = 1'b0;
        e.res = '0;
        e.cyc = 0;
        case (sel)
            OP_AND:  e.res = a & b;
            OP_OR:   e.res = a | b;
            OP_ADD:  e.res = a + b;
            OP_SUB:  e.res = a - b;
            OP_SLT:  begin e.lt = ($signed(a) < $signed(b)); e.res = {31'b0, e.lt}; end
            OP_SLTU: begin e.lt = (a < b); e.res = {31'b0, e.lt}; end
            OP_SLL:  e.res = a << sh;
            OP_SRL:  e.res = a >> sh;
            OP_SRA:  e.res = $signed(a) >>> sh;
            OP_XOR:  e.res = a ^ b;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Called at negedge+1; returns at negedge+1 after the accepting edge.
    task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        int   sh;
        n = 0;
        while (busy && n < 100) begin
            start = 1'b0;
            @(negedge clk); #1;
            n++;
        end
        if (busy) begin
            nvec++;
            nfail++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", busy, n);
        end
        outsel = sel;
        opa    = a;
        opb    = b;
        start  = 1'b1;
        e  = model(sel, a, b);
        sh = is_shift(sel) ? int'(b[4:0]) : 0;
        e.cyc = cyc + 1 + sh;
        if (sh > 0) begin
            bfrom = cyc + 1;
            bto   = cyc + sh;
        end
        q.push_back(e);
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin @(negedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("busy", 32'(busy), 32'((cyc >= bfrom) && (cyc <= bto)));
            if (done) begin
                if (q.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL spurious_done: done=1 with no outstanding op (cycle %0d), required 0", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("result", result, e.res);
                    chk("eq", 32'(eq), 32'(e.eq));
                    chk("lt", 32'(lt), 32'(e.lt));
                    chk("illegal", 32'(illegal), 32'(e.ill));
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                e = q.pop_front();
                nvec++;
                nfail++;
                $display("FAIL missing_done: done=0 at cycle %0d, required 1 at cycle %0d", cyc, e.cyc);
            end
        end
    end

    initial begin
        logic [3:0]  legal [10];
        logic [3:0]  bad [6];
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        legal = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_XOR};
        bad   = '{4'b0011, 4'b0100, 4'b0101, 4'b1101, 4'b1110, OP_NONE};

        start = 1'b1;
        outsel = OP_ADD;
        opa = 32'd5;
        opb = 32'd5;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_result", result, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_eq", 32'(eq), 32'd0);
        chk("rst_lt", 32'(lt), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        start  = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Reset aborts a shift in progress
        issue(OP_SLL, 32'h1234_5678, 32'd20);
        repeat (4) begin @(negedge clk); #1; end
        rst_n = 1'b0;
        q.delete();
        bfrom = -1;
        bto   = -2;
        @(negedge clk); #1;
        chk("abort_result", result, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        issue(OP_ADD, 32'd1, 32'd2);
        idle(2);

        issue(OP_ADD, 32'hFFFF_FFFF, 32'd1);
        issue(OP_SUB, 32'd5, 32'd5);
        issue(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        issue(OP_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0);
        issue(OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        idle(1);
        issue(OP_SLT,  32'h8000_0000, 32'd1);
        issue(OP_SLTU, 32'h8000_0000, 32'd1);
        issue(OP_SLT,  32'd7, 32'd7);
        issue(OP_SRA, 32'h8000_0000, 32'd31);
        issue(OP_SRL, 32'h8000_0000, 32'd31);
        issue(OP_SLL, 32'd1, 32'd0);
        idle(2);

        // Back-to-back ADDs with start held
        issue(OP_ADD, 32'd10, 32'd20);
        issue(OP_ADD, 32'd30, 32'd40);
        issue(OP_ADD, 32'hDEAD_BEEF, 32'h1111_1111);
        idle(1);

        // start pulsed mid-shift must be dropped
        issue(OP_SRL, 32'hA5A5_0000, 32'd10);
        @(negedge clk); #1;
        outsel = OP_ADD;
        opa    = 32'd9;
        opb    = 32'd9;
        start  = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        idle(12);

        issue(OP_NONE, 32'd3, 32'd3);
        issue(OP_ADD, 32'd3, 32'd4);
        idle(1);

        for (int i = 0; i < 150; i++) begin
            sel = ($urandom_range(11) == 0) ? bad[$urandom_range(5)] : legal[$urandom_range(9)];
            a   = $urandom;
            b   = ($urandom_range(3) == 0) ? a : $urandom;
            issue(sel, a, b);
            if ($urandom_range(2) == 0) idle($urandom_range(2));
        end

        n = 0;
        start = 1'b0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (q.size() > 0) begin
            nvec++;
            nfail++;
            $display("FAIL drain: %0d ops still outstanding, required 0", q.size());
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
